// File: rtl/wrf_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one 16-bit WR fabric TX port among NUM_SRC sources.
// Optional mid-frame idle timeout is built only when WRF_ARB_TIMEOUT_EN is defined.
module wrf_tx_arbiter #(
  parameter int NUM_SRC        = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  wrf_clk,
  input  logic                  wrf_rst_n,
  input  logic [NUM_SRC-1:0]    src_valid,
  input  logic [16*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]    src_last,
  output logic [NUM_SRC-1:0]    src_stall,
  output logic                  wrf_valid,
  output logic [15:0]           wrf_data,
  output logic                  wrf_last,
  input  logic                  wrf_stall,
  output logic [2:0]            grant_id,
  output logic                  busy,
  output logic [15:0]           frame_count,
  output logic                  timeout_err
);

  // state   | meaning
  // S_IDLE  | no owner; port quiet, every source stalled, arbitration runs
  // S_GRANT | grant_id owns the port until a transferred last word (or timeout)
  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t      state, state_nxt;
  logic [2:0]  ptr, ptr_nxt;
  logic [2:0]  grant_nxt;
  logic [15:0] frame_nxt;
  logic [2:0]  sel;
  logic        any_req;
  logic        g_valid, g_last;
  logic [15:0] g_data;
  logic        timeout_hit;

  assign any_req = |src_valid;

  // Descending k so the candidate closest after ptr is written last and wins.
  always_comb begin
    sel = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (src_valid[j] && (((int'(ptr) + k) % NUM_SRC) == j)) sel = 3'(j);
      end
    end
  end

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (grant_id == 3'(j)) begin
        g_valid = src_valid[j];
        g_last  = src_last[j];
        g_data  = src_data[16*j +: 16];
      end
    end
  end

`ifdef WRF_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] idle_cnt;

  // Fires during the idle cycle that brings the count to TIMEOUT_CYCLES.
  assign timeout_hit = (state == S_GRANT) && !g_valid &&
                       (idle_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wrf_clk or negedge wrf_rst_n) begin
    if (!wrf_rst_n) begin
      idle_cnt <= '0;
    end else if (state != S_GRANT || g_valid || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  // No counter in this build; the limit parameter has no effect.
  assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

  assign timeout_err = timeout_hit;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    ptr_nxt   = ptr;
    frame_nxt = frame_count;
    busy      = 1'b0;
    wrf_valid = 1'b0;
    wrf_data  = '0;
    wrf_last  = 1'b0;
    src_stall = '1;
    case (state)
      S_IDLE: begin
        if (any_req) begin
          state_nxt = S_GRANT;
          grant_nxt = sel;
        end
      end
      S_GRANT: begin
        busy      = 1'b1;
        wrf_valid = g_valid;
        wrf_data  = g_data;
        wrf_last  = g_last;
        for (int j = 0; j < NUM_SRC; j++) begin
          if (grant_id == 3'(j)) src_stall[j] = wrf_stall;
        end
        if (g_valid && !wrf_stall && g_last) begin
          state_nxt = S_IDLE;
          ptr_nxt   = grant_id;
          frame_nxt = frame_count + 16'd1;
        end else if (timeout_hit) begin
          state_nxt = S_IDLE;
          ptr_nxt   = grant_id;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wrf_clk or negedge wrf_rst_n) begin
    if (!wrf_rst_n) begin
      state       <= S_IDLE;
      grant_id    <= '0;
      ptr         <= 3'(NUM_SRC - 1);
      frame_count <= '0;
    end else begin
      state       <= state_nxt;
      grant_id    <= grant_nxt;
      ptr         <= ptr_nxt;
      frame_count <= frame_nxt;
    end
  end

endmodule
